regfile_rename: RTL

Parametrised architectural register file with per-register rename state (busy flag plus producing ROB tag) for the out-of-order RISC-V core. It sits between the decoder, which reads source operands and renames destinations, and the ROB, which commits results in order. It generalises register count, data and tag width, and read-port count. Over a plain rename table it adds x0 hardwiring, commit-to-read bypass, rename-over-commit priority, and a registered busy-register counter for dispatch throttling.

---
 rtl/regfile_rename_if.sv | 40 ++++
 rtl/regfile_rename.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_rename_if.sv
// Decoder/ROB facing bundle of the renaming register file.
// Master drives operand reads, renames and commits; slave answers.
interface regfile_rename_if #(
    parameter int DATA_W   = 32,
    parameter int REG_N    = 32,
    parameter int ROB_ID_W = 4,
    parameter int N_RD     = 2
);
    localparam int REG_ID_W = $clog2(REG_N);
    localparam int CNT_W    = $clog2(REG_N + 1);

    logic                       rdy;
    logic                       rollback;
    logic [N_RD*REG_ID_W-1:0]   rd_addr;
    logic [N_RD-1:0]            rd_busy;
    logic [N_RD*DATA_W-1:0]     rd_data;
    logic [N_RD*ROB_ID_W-1:0]   rd_rob_id;
    logic                       ren_en;
    logic [REG_ID_W-1:0]        ren_rd;
    logic [ROB_ID_W-1:0]        ren_rob_id;
    logic                       cmt_en;
    logic [REG_ID_W-1:0]        cmt_rd;
    logic [DATA_W-1:0]          cmt_data;
    logic [ROB_ID_W-1:0]        cmt_rob_id;
    logic [CNT_W-1:0]           busy_cnt;

    modport master (
        output rdy, rollback, rd_addr,
        output ren_en, ren_rd, ren_rob_id,
        output cmt_en, cmt_rd, cmt_data, cmt_rob_id,
        input  rd_busy, rd_data, rd_rob_id, busy_cnt
    );

    modport slave (
        input  rdy, rollback, rd_addr,
        input  ren_en, ren_rd, ren_rob_id,
        input  cmt_en, cmt_rd, cmt_data, cmt_rob_id,
        output rd_busy, rd_data, rd_rob_id, busy_cnt
    );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy/tag rename state,
// x0 hardwiring, commit-to-read bypass and a registered busy counter.
module regfile_rename #(
    parameter int DATA_W   = 32,
    parameter int REG_N    = 32,
    parameter int ROB_ID_W = 4,
    parameter int N_RD     = 2
) (
    input  logic             clk,
    input  logic             rst,
    regfile_rename_if.slave  bus
);
    localparam int REG_ID_W = $clog2(REG_N);
    localparam int CNT_W    = $clog2(REG_N + 1);

    logic [DATA_W-1:0]   data_q [REG_N];
    logic [DATA_W-1:0]   data_d [REG_N];
    logic [ROB_ID_W-1:0] tag_q  [REG_N];
    logic [ROB_ID_W-1:0] tag_d  [REG_N];
    logic [REG_N-1:0]    busy_q;
    logic [REG_N-1:0]    busy_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [REG_ID_W-1:0] ra [N_RD];
    logic                cmt_ok;
    logic                ren_ok;
    logic                cmt_hit;

    for (genvar k = 0; k < N_RD; k++) begin : g_ra
        assign ra[k] = bus.rd_addr[k*REG_ID_W +: REG_ID_W];
    end

    assign cmt_ok  = bus.cmt_en && (bus.cmt_rd != '0);
    assign ren_ok  = bus.ren_en && (bus.ren_rd != '0) && !bus.rollback;
    assign cmt_hit = cmt_ok && busy_q[bus.cmt_rd]
                   && (tag_q[bus.cmt_rd] == bus.cmt_rob_id);

    // Operand read: x0 is zero, a matching commit bypasses, else table state.
    always_comb begin
        bus.rd_busy   = '0;
        bus.rd_data   = '0;
        bus.rd_rob_id = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (ra[k] != '0) begin
                if (cmt_hit && (bus.cmt_rd == ra[k])) begin
                    bus.rd_data[k*DATA_W +: DATA_W] = bus.cmt_data;
                end else if (busy_q[ra[k]]) begin
                    bus.rd_busy[k] = 1'b1;
                    bus.rd_rob_id[k*ROB_ID_W +: ROB_ID_W] = tag_q[ra[k]];
                end else begin
                    bus.rd_data[k*DATA_W +: DATA_W] = data_q[ra[k]];
                end
            end
        end
    end

    // Next state: commit writes data, rollback wipes rename, rename wins busy.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        cnt_d  = '0;
        if (cmt_ok) begin
            data_d[bus.cmt_rd] = bus.cmt_data;
        end
        if (cmt_hit) begin
            busy_d[bus.cmt_rd] = 1'b0;
        end
        if (bus.rollback) begin
            busy_d = '0;
            for (int i = 0; i < REG_N; i++) begin
                tag_d[i] = '0;
            end
        end
        if (ren_ok) begin
            busy_d[bus.ren_rd] = 1'b1;
            tag_d[bus.ren_rd]  = bus.ren_rob_id;
        end
        for (int i = 0; i < REG_N; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers, frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < REG_N; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (bus.rdy) begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign bus.busy_cnt = cnt_q;
endmodule
